// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one fixed-latency synchronous sprite ROM
// among N_REQ requesters. A tag pipeline follows each read so the returned
// word is steered back to the requester that issued it.
module sprite_rom_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_i,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   addr_i,
    output logic [N_REQ-1:0]              gnt_o,
    output logic                          rom_en_o,
    output logic [ADDR_WIDTH-1:0]         rom_addr_o,
    input  logic [DATA_WIDTH-1:0]         rom_data_i,
    output logic [N_REQ-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned DEPTH = READ_LATENCY + 1;

    logic [N_REQ-1:0]            gnt_q, gnt_d;
    logic                        rom_en_q, rom_en_d;
    logic [ADDR_WIDTH-1:0]       rom_addr_q, rom_addr_d;
    logic [IDX_W-1:0]            last_q, last_d;
    logic [DEPTH-1:0][N_REQ-1:0] tag_q, tag_d;
    logic [N_REQ-1:0]            rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;

    logic [N_REQ-1:0]            eligible;
    logic                        win_found;
    logic [IDX_W-1:0]            win_idx;

    // Round-robin search starting just after the last winner; a requester
    // granted this cycle is masked so a held request is not granted twice.
    always_comb begin
        eligible  = req_i & ~gnt_q;
        win_found = 1'b0;
        win_idx   = last_q;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((32'(last_q) + k) % N_REQ);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state: grant/ROM request, tag shift and response steering.
    always_comb begin
        gnt_d      = '0;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        last_d     = last_q;
        tag_d      = '0;
        rvalid_d   = '0;
        rdata_d    = rdata_q;
        if (en_i) begin
            if (win_found) begin
                gnt_d      = N_REQ'(1) << win_idx;
                rom_en_d   = 1'b1;
                rom_addr_d = addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                last_d     = win_idx;
            end
            tag_d[0] = gnt_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                tag_d[i] = tag_q[i-1];
            end
            rvalid_d = tag_q[READ_LATENCY];
            if (|tag_q[READ_LATENCY]) begin
                rdata_d = rom_data_i;
            end
        end
    end

    // State registers; reset returns top priority to requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            last_q     <= IDX_W'(N_REQ - 1);
            tag_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            gnt_q      <= gnt_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            last_q     <= last_d;
            tag_q      <= tag_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign rom_en_o   = rom_en_q;
    assign rom_addr_o = rom_addr_q;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a 2-cycle ROM model whose
// word at address a is a ^ 12'hFFF.
module tb_sprite_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [3:0]  req = '0;
    logic [47:0] addr = '0;
    logic [3:0]  gnt_o;
    logic        rom_en_o;
    logic [11:0] rom_addr_o;
    logic [11:0] rom_data;
    logic [3:0]  rvalid_o;
    logic [11:0] rdata_o;

    logic [11:0] rom_p1 = '0;
    logic [11:0] rom_p2 = '0;

    int errors = 0;
    int checks = 0;

    // Expected tables for the rotation and lone-requester tests.
    logic [3:0]  rot_g [1:9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  rot_v [1:9] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0};
    logic [11:0] rot_d [1:9] = '{12'h0, 12'h0, 12'h0, 12'hEFF, 12'hEFE, 12'hEFD, 12'hEFC, 12'hEFF, 12'h0};
    logic [3:0]  lone_g [1:8] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    logic [3:0]  lone_v [1:8] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1};

    sprite_rom_arbiter #(
        .N_REQ(4), .ADDR_WIDTH(12), .DATA_WIDTH(12), .READ_LATENCY(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .req_i      (req),
        .addr_i     (addr),
        .gnt_o      (gnt_o),
        .rom_en_o   (rom_en_o),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, two cycles from enable to data.
    always @(posedge clk) begin
        if (rom_en_o) rom_p1 <= rom_addr_o ^ 12'hFFF;
        rom_p2 <= rom_p1;
    end
    assign rom_data = rom_p2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        req = '0;
        tick();
        tick();
        chk("rst_gnt",    32'(gnt_o),      32'h0);
        chk("rst_rom_en", 32'(rom_en_o),   32'h0);
        chk("rst_addr",   32'(rom_addr_o), 32'h0);
        chk("rst_rvalid", 32'(rvalid_o),   32'h0);
        chk("rst_rdata",  32'(rdata_o),    32'h0);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single request from requester 2.
        do_reset();
        addr[2*12 +: 12] = 12'h123;
        req = 4'b0100;
        tick();
        chk("t1_gnt",    32'(gnt_o),      32'h4);
        chk("t1_rom_en", 32'(rom_en_o),   32'h1);
        chk("t1_addr",   32'(rom_addr_o), 32'h123);
        req = 4'b0000;
        tick();
        chk("t1_gnt_c2", 32'(gnt_o), 32'h0);
        chk("t1_en_c2",  32'(rom_en_o), 32'h0);
        tick();
        chk("t1_rv_c3",  32'(rvalid_o), 32'h0);
        tick();
        chk("t1_rv_c4",  32'(rvalid_o), 32'h4);
        chk("t1_rd_c4",  32'(rdata_o),  32'hEDC);
        tick();
        chk("t1_rv_c5",  32'(rvalid_o), 32'h0);
        chk("t1_gnt_c5", 32'(gnt_o),    32'h0);

        // Round-robin rotation with all four requesting.
        do_reset();
        for (int i = 0; i < 4; i++) addr[i*12 +: 12] = 12'h100 + 12'(i);
        req = 4'b1111;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("rot_gnt_c%0d", c), 32'(gnt_o), 32'(rot_g[c]));
            chk($sformatf("rot_rv_c%0d", c),  32'(rvalid_o), 32'(rot_v[c]));
            if (rot_v[c] != 4'h0)
                chk($sformatf("rot_rd_c%0d", c), 32'(rdata_o), 32'(rot_d[c]));
            if (c == 5) req = 4'b0000;
        end

        // Lone held requester is granted every other cycle.
        do_reset();
        addr[0 +: 12] = 12'h055;
        req = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("lone_gnt_c%0d", c), 32'(gnt_o), 32'(lone_g[c]));
            chk($sformatf("lone_rv_c%0d", c),  32'(rvalid_o), 32'(lone_v[c]));
            if (lone_v[c] != 4'h0)
                chk($sformatf("lone_rd_c%0d", c), 32'(rdata_o), 32'hFAA);
            if (c == 5) req = 4'b0000;
        end

        // Wrap from requester 3 back to requester 0.
        do_reset();
        addr[0 +: 12]    = 12'h00A;
        addr[3*12 +: 12] = 12'h3C0;
        req = 4'b1000;
        tick();
        chk("wrap_gnt_c1", 32'(gnt_o), 32'h8);
        req = 4'b1001;
        tick();
        chk("wrap_gnt_c2", 32'(gnt_o), 32'h1);
        chk("wrap_addr_c2", 32'(rom_addr_o), 32'h00A);
        tick();
        chk("wrap_gnt_c3", 32'(gnt_o), 32'h8);
        req = 4'b0000;
        tick();
        chk("wrap_gnt_c4", 32'(gnt_o), 32'h0);
        chk("wrap_rv_c4", 32'(rvalid_o), 32'h8);
        chk("wrap_rd_c4", 32'(rdata_o), 32'hC3F);
        tick();
        chk("wrap_rv_c5", 32'(rvalid_o), 32'h1);
        chk("wrap_rd_c5", 32'(rdata_o), 32'hFF5);
        tick();
        chk("wrap_rv_c6", 32'(rvalid_o), 32'h8);
        chk("wrap_rd_c6", 32'(rdata_o), 32'hC3F);
        tick();
        chk("wrap_rv_c7", 32'(rvalid_o), 32'h0);

        // Flush via en_i with two reads in flight.
        do_reset();
        addr[0 +: 12]    = 12'h111;
        addr[1*12 +: 12] = 12'h222;
        addr[3*12 +: 12] = 12'h333;
        req = 4'b0011;
        tick();
        chk("fl_gnt_c1", 32'(gnt_o), 32'h1);
        req = 4'b0010;
        tick();
        chk("fl_gnt_c2", 32'(gnt_o), 32'h2);
        req = 4'b0000;
        tick();
        chk("fl_rv_c3", 32'(rvalid_o), 32'h0);
        en = 1'b0;
        tick();
        chk("fl_gnt_c4", 32'(gnt_o), 32'h0);
        chk("fl_en_c4",  32'(rom_en_o), 32'h0);
        chk("fl_rv_c4",  32'(rvalid_o), 32'h0);
        en  = 1'b1;
        req = 4'b1001;
        tick();
        chk("fl_gnt_c5",  32'(gnt_o), 32'h8);
        chk("fl_addr_c5", 32'(rom_addr_o), 32'h333);
        chk("fl_rv_c5",   32'(rvalid_o), 32'h0);
        req = 4'b0000;
        tick();
        chk("fl_rv_c6", 32'(rvalid_o), 32'h0);
        tick();
        chk("fl_rv_c7", 32'(rvalid_o), 32'h0);
        tick();
        chk("fl_rv_c8", 32'(rvalid_o), 32'h8);
        chk("fl_rd_c8", 32'(rdata_o), 32'hCCC);

        // Asynchronous reset between edges with two reads in flight.
        do_reset();
        addr[0 +: 12]    = 12'h111;
        addr[1*12 +: 12] = 12'h0F0;
        addr[3*12 +: 12] = 12'h00F;
        req = 4'b0011;
        tick();
        chk("ar_gnt_c1", 32'(gnt_o), 32'h1);
        req = 4'b0010;
        tick();
        chk("ar_gnt_c2", 32'(gnt_o), 32'h2);
        req = 4'b0000;
        #3;
        rst = 1'b1;
        #1;
        chk("ar_gnt_rst",  32'(gnt_o), 32'h0);
        chk("ar_en_rst",   32'(rom_en_o), 32'h0);
        chk("ar_addr_rst", 32'(rom_addr_o), 32'h0);
        chk("ar_rv_rst",   32'(rvalid_o), 32'h0);
        tick();
        rst = 1'b0;
        req = 4'b1010;
        tick();
        chk("ar_gnt_p1", 32'(gnt_o), 32'h2);
        chk("ar_rv_p1",  32'(rvalid_o), 32'h0);
        req = 4'b1000;
        tick();
        chk("ar_gnt_p2", 32'(gnt_o), 32'h8);
        chk("ar_rv_p2",  32'(rvalid_o), 32'h0);
        req = 4'b0000;
        tick();
        chk("ar_rv_p3", 32'(rvalid_o), 32'h0);
        tick();
        chk("ar_rv_p4", 32'(rvalid_o), 32'h2);
        chk("ar_rd_p4", 32'(rdata_o), 32'hF0F);
        tick();
        chk("ar_rv_p5", 32'(rvalid_o), 32'h8);
        chk("ar_rd_p5", 32'(rdata_o), 32'hFF0);
        tick();
        chk("ar_rv_p6", 32'(rvalid_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
